// File: rtl/i2c_write_engine.sv
// I2C master write: START, three bytes (slave addr, sub addr, data) each with an ACK slot, then STOP.
// Bus pins are registered one iCLK behind the FSM; oEND rises 116*Q+1 cycles after iGO is taken; NACKs never abort.
module i2c_write_engine #(
    parameter int CLK_Freq = 50000000,
    parameter int I2C_Freq = 20000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [23:0] iDATA,
    input  logic        iGO,
    output logic        oEND,
    output logic        oACK,
    output logic        oBUSY,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT
);
    localparam int Q  = CLK_Freq / (4 * I2C_Freq);
    localparam int QW = (Q > 1) ? $clog2(Q) : 1;
    localparam logic [QW-1:0] QLAST = QW'(Q - 1);

    typedef enum logic [2:0] {IDLE, START, SHIFT, ACKBIT, STOP, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [QW-1:0] qcnt;
    logic [1:0]    phase;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic [23:0]   data_q;
    logic          scl_q;
    logic          sda_low_q;
    logic          end_q;
    logic          ack_q;
    logic          busy_q;
    logic          scl_d;
    logic          sda_low_d;
    logic          wrap;
    logic          bit_end;

    assign wrap    = (qcnt == QLAST);
    assign bit_end = wrap && (phase == 2'd3);

    always_comb begin
        state_nxt = state;
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
        case (state)
            IDLE: begin
                if (iGO) state_nxt = START;
            end
            START: begin
                scl_d     = (phase != 2'd3);
                sda_low_d = (phase != 2'd0);
                if (bit_end) state_nxt = SHIFT;
            end
            SHIFT: begin
                // SCL high only in the middle two quarters; SDA is stable across the whole bit
                scl_d     = phase[0] ^ phase[1];
                sda_low_d = ~data_q[23];
                if (bit_end && (bit_cnt == 3'd0)) state_nxt = ACKBIT;
            end
            ACKBIT: begin
                scl_d = phase[0] ^ phase[1];
                if (bit_end) state_nxt = (byte_cnt == 2'd2) ? STOP : SHIFT;
            end
            STOP: begin
                scl_d     = (phase != 2'd0);
                sda_low_d = (phase != 2'd3);
                if (bit_end) state_nxt = DONE;
            end
            DONE: begin
                if (!iGO) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state     <= IDLE;
            qcnt      <= '0;
            phase     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            data_q    <= '0;
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
            end_q     <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            scl_q     <= scl_d;
            sda_low_q <= sda_low_d;
            case (state)
                IDLE: begin
                    qcnt  <= '0;
                    phase <= '0;
                    if (iGO) begin
                        data_q   <= iDATA;
                        bit_cnt  <= 3'd7;
                        byte_cnt <= '0;
                        end_q    <= 1'b0;
                        ack_q    <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                // First DONE cycle publishes completion, giving the extra cycle after STOP
                DONE: begin
                    end_q  <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: begin
                    qcnt <= wrap ? '0 : qcnt + 1'b1;
                    if (wrap) phase <= phase + 2'd1;
                    if ((state == ACKBIT) && (phase == 2'd2) && wrap && I2C_SDAT)
                        ack_q <= 1'b1;
                    if (bit_end && (state == SHIFT)) begin
                        data_q  <= {data_q[22:0], 1'b0};
                        bit_cnt <= bit_cnt - 3'd1;
                    end
                    if (bit_end && (state == ACKBIT)) begin
                        bit_cnt  <= 3'd7;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
            endcase
        end
    end

    assign oEND     = end_q;
    assign oACK     = ack_q;
    assign oBUSY    = busy_q;
    assign I2C_SCLK = scl_q;
    assign I2C_SDAT = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_write_engine.sv
// Directed bench for i2c_write_engine at Q=2: a slave model ACKs/NACKs per byte, a scoreboard checks every SCL-high bit.
module tb_i2c_write_engine;
    localparam int CLKF = 160;
    localparam int I2CF = 20;
    localparam int LAT  = 233;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [23:0] data = '0;
    logic        end_f;
    logic        ack;
    logic        busy;
    logic        scl;
    tri1         sda;
    logic        slave_low = 1'b0;

    assign sda = slave_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_write_engine #(.CLK_Freq(CLKF), .I2C_Freq(I2CF)) dut (
        .iCLK(clk), .iRST_N(rst_n), .iDATA(data), .iGO(go),
        .oEND(end_f), .oACK(ack), .oBUSY(busy),
        .I2C_SCLK(scl), .I2C_SDAT(sda)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    logic       exp_q[$];
    logic [2:0] nack_mask = '0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         rises = 0;
    int         starts = 0;
    int         stops = 0;
    int         bitpos = 0;
    int         byte_idx = 0;

    // Bus monitor, protocol checker, scoreboard consumer and slave model
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            slave_low = 1'b0;
            bitpos    = 0;
            byte_idx  = 0;
        end
        if (scl && !prev_scl) begin
            rises++;
            bitpos++;
            if (exp_q.size() == 0) check($sformatf("extra_scl_rise%0d", rises), 32'(sda), 32'hx);
            else check($sformatf("sda_bit_rise%0d", rises), 32'(sda), 32'(exp_q.pop_front()));
        end
        if (!scl && prev_scl && rst_n) begin
            if (bitpos == 8 && byte_idx < 3 && !nack_mask[byte_idx[1:0]]) slave_low = 1'b1;
            else if (bitpos == 9) begin
                slave_low = 1'b0;
                bitpos    = 0;
                byte_idx++;
            end
        end
        if (scl && prev_scl && (sda !== prev_sda)) begin
            if (!sda) begin
                starts++;
                bitpos   = 0;
                byte_idx = 0;
            end else stops++;
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    task automatic push_exp(input logic [23:0] d, input logic [2:0] nack);
        for (int b = 0; b < 3; b++) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back(d[8*(2-b)+i]);
            exp_q.push_back(nack[b]);
        end
        exp_q.push_back(1'b0);
    endtask

    task automatic run_xfer(input string name, input logic [23:0] d, input logic [2:0] nack,
                            input bit corrupt);
        int lat;
        int s0;
        int p0;
        s0 = starts;
        p0 = stops;
        push_exp(d, nack);
        @(negedge clk);
        nack_mask = nack;
        data = d;
        go = 1'b1;
        @(posedge clk); #2;
        check({name, "_start_end"}, 32'(end_f), 0);
        check({name, "_start_busy"}, 32'(busy), 1);
        lat = 0;
        while (!end_f && lat < 1000) begin
            @(posedge clk); #2;
            lat++;
            if (corrupt && lat == 40) data = 24'hFFFFFF;
            if (corrupt && lat == 60) go = 1'b0;
            if (corrupt && lat == 80) go = 1'b1;
            if (corrupt && lat == 90) go = 1'b0;
        end
        check({name, "_end_latency"}, 32'(lat), LAT);
        check({name, "_busy_done"}, 32'(busy), 0);
        check({name, "_ack"}, 32'(ack), 32'(nack != 3'b000));
        check({name, "_bits_left"}, 32'(exp_q.size()), 0);
        check({name, "_starts"}, 32'(starts - s0), 1);
        check({name, "_stops"}, 32'(stops - p0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int lat;
        repeat (3) @(posedge clk);
        #2;
        check("rst_scl", 32'(scl), 1);
        check("rst_sda", 32'(sda), 1);
        check("rst_end", 32'(end_f), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_xfer("all_ack", 24'h34001A, 3'b000, 1'b0);

        // iGO stays high after completion: no retrigger, no SCL activity
        r0 = rises;
        repeat (500) @(posedge clk);
        #2;
        check("hold_rises", 32'(rises - r0), 0);
        check("hold_end", 32'(end_f), 1);
        check("hold_scl", 32'(scl), 1);
        @(negedge clk);
        go = 1'b0;
        @(posedge clk);

        run_xfer("nack_b1", 24'h34001A, 3'b010, 1'b0);
        @(negedge clk);
        go = 1'b0;
        repeat (2) @(posedge clk);

        run_xfer("data_change", 24'h34001A, 3'b000, 1'b1);
        @(negedge clk);
        go = 1'b0;
        repeat (2) @(posedge clk);

        // Reset in byte 1, bit 4 (13th SCL rise of the transfer)
        r0 = rises;
        push_exp(24'h34001A, 3'b001);
        @(negedge clk);
        nack_mask = 3'b001;
        data = 24'h34001A;
        go = 1'b1;
        lat = 0;
        while ((rises - r0) < 13 && lat < 2000) begin
            @(posedge clk); #2;
            lat++;
        end
        check("mid_reach", 32'(rises - r0), 13);
        check("mid_ack_before", 32'(ack), 1);
        rst_n = 1'b0;
        go = 1'b0;
        @(posedge clk); #2;
        check("mid_rst_scl", 32'(scl), 1);
        check("mid_rst_sda", 32'(sda), 1);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_end", 32'(end_f), 0);
        check("mid_rst_ack", 32'(ack), 0);
        exp_q.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_xfer("after_rst", 24'hA55AC3, 3'b100, 1'b0);
        @(negedge clk);
        go = 1'b0;
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2c_write_engine.md
I2C_WRITE_ENGINE -- requirements
Module: i2c_write_engine

Interface
REQ-001 Parameter CLK_Freq, default 50000000: iCLK frequency in Hz.
REQ-002 Parameter I2C_Freq, default 20000: target SCL frequency in Hz.
REQ-003 Q = CLK_Freq/(4*I2C_Freq), integer-truncated, is the quarter-bit period in iCLK cycles (625 at defaults); Q >= 1 is required.
REQ-004 iCLK  in  1  sole clock; all logic on its rising edge.
REQ-005 iRST_N  in  1  reset, synchronous, active-low.
REQ-006 iDATA  in  24  {slave_addr[7:0], sub_addr[7:0], data[7:0]}, sent MSB first.
REQ-007 iGO  in  1  transfer request, level.
REQ-008 oEND  out  1  transfer complete flag.
REQ-009 oACK  out  1  1 = at least one NACK in the last transfer; 0 = all three bytes acknowledged.
REQ-010 oBUSY  out  1  1 from transfer start until oEND rises.
REQ-011 I2C_SCLK  out  1  I2C clock, push-pull.
REQ-012 I2C_SDAT  inout  1  I2C data, open-drain: drives 0 or high-Z, never drives 1.

Function
REQ-013 A quarter-tick counter shall count 0..Q-1, reset to 0 on transfer start, and advance the bit phase on each wrap.
REQ-014 FSM states: IDLE, START, SHIFT, ACKBIT, STOP, DONE.
REQ-015 IDLE: SCL=1, SDA released; on an edge that samples iGO=1, latch iDATA, clear oEND and oACK, set oBUSY, go to START.
REQ-016 START, 4 quarters (SCL,SDA): (1,1), (1,0), (1,0), (0,0).
REQ-017 SHIFT, 4 quarters per bit: q0 SCL=0 with SDA = current bit; q1 and q2 SCL=1; q3 SCL=0; SDA held through all four quarters.
REQ-018 Bit order: 8 bits per byte, MSB first; 3-bit counter counts 7..0, then go to ACKBIT.
REQ-019 ACKBIT: same 4-quarter SCL pattern, SDA released; sample I2C_SDAT on the last iCLK of q2; sampled 1 sets the sticky oACK.
REQ-020 After ACKBIT, a 2-bit byte counter increments; bytes 0 and 1 return to SHIFT, byte 2 goes to STOP.
REQ-021 A NACK shall not abort the transfer; all 3 bytes are always sent.
REQ-022 STOP, 4 quarters (SCL,SDA): (0,0), (1,0), (1,0), (1,released).
REQ-023 At the end of STOP: oEND=1, oBUSY=0, go to DONE; oEND rises exactly 116*Q+1 iCLK cycles after the edge that sampled iGO=1.
REQ-024 DONE: hold oEND=1 and oACK while iGO=1; go to IDLE on the first edge that samples iGO=0. oEND stays 1 in IDLE until the next start.
REQ-025 A new transfer requires iGO to be sampled 0 after oEND; iGO held high never retriggers.
REQ-026 iDATA and iGO changes during a transfer shall be ignored.

Reset
REQ-027 On iRST_N=0 at a clock edge, from any state: FSM=IDLE, all counters 0, SCL=1, SDA released, oEND=0, oACK=0, oBUSY=0, latched data 0.
REQ-028 Reset mid-transfer abandons the transfer immediately with no STOP generated.

Verification (Q=2, i.e. CLK_Freq=160, I2C_Freq=20)
REQ-029 iDATA=24'h34001A, iGO=1, slave model ACKs all bytes -> SDA bit stream 0011_0100 A 0000_0000 A 0001_1010 A; oEND=1 at cycle 233; oACK=0.
REQ-030 Same transfer, slave NACKs the second byte only -> all 27 bits still clocked, STOP generated, oEND=1, oACK=1.
REQ-031 iGO held 1 for 500 cycles after oEND -> no further SCL edges, oEND remains 1; iGO=0 then 1 -> new START, oEND=0 on the next edge.
REQ-032 iRST_N=0 during byte 1 bit 4 -> on the next edge SCL=1, SDA=Z, oBUSY=0, oEND=0, oACK=0; after release, a fresh iGO yields a complete transfer.
REQ-033 iDATA changed to 24'hFFFFFF mid-transfer -> transmitted bits match the originally latched value.
REQ-034 A protocol checker confirms SDA changes only while SCL=0, except the START and STOP edges.
